// File: rtl/rr_hold_arbiter_if.sv
// rr_hold_arbiter_if: request/grant bundle for rr_hold_arbiter.
//   en       - allows new grants (master -> arbiter)
//   rrMode   - 1 = round-robin, 0 = fixed priority (master -> arbiter)
//   req      - N request bits (master -> arbiter)
//   gnt      - registered one-hot grant (arbiter -> master)
//   gntValid - registered |gnt (arbiter -> master)
//   gntIdx   - registered owner index, holds last owner when idle
// IDXW is derived from N and should not be overridden.
interface rr_hold_arbiter_if #(
  parameter int N    = 8,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
);
  logic            en;
  logic            rrMode;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            gntValid;
  logic [IDXW-1:0] gntIdx;

  modport master (output en, rrMode, req, input gnt, gntValid, gntIdx);
  modport slave  (input en, rrMode, req, output gnt, gntValid, gntIdx);
endinterface

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: registered N-way arbiter, fixed priority or round-robin,
// grant held until the owner releases, optional hold limit that lets a
// waiting requester preempt a long-running owner.
//   clk - clock
//   rst - synchronous active-high reset
//   bus - rr_hold_arbiter_if slave side (en, rrMode, req in; gnt, gntValid,
//         gntIdx out). Interface N must match this module's N.
//
// state | meaning
// IDLE  | no grant outstanding, waiting for en and a request
// GRANT | gnt_idx_q owns the resource, hold_cnt_q counts its cycles
module rr_hold_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input logic              clk,
  input logic              rst,
  rr_hold_arbiter_if.slave bus
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  // With no hold limit the counter only needs to saturate somewhere.
  localparam int HCW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 8;
  localparam logic [HCW-1:0] HOLD_SAT = (MAX_HOLD > 0) ? HCW'(MAX_HOLD) : {HCW{1'b1}};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            gnt_valid_q;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;

  logic [N-1:0]    others;
  logic            owner_req;
  logic [IDXW-1:0] owner_nxt;
  logic [IDXW-1:0] scan_start;
  logic [IDXW-1:0] win_req;
  logic [IDXW-1:0] win_pre;

  // First set bit of m scanning start, start+1, ... wrapping at N.
  function automatic logic [IDXW-1:0] pick(input logic [N-1:0] m,
                                           input logic [IDXW-1:0] start);
    logic [IDXW-1:0] w;
    logic            hit;
    logic [N-1:0]    sh;
    int              idx;
    w   = '0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      sh = m >> idx;
      if (!hit && sh[0]) begin
        hit = 1'b1;
        w   = IDXW'(idx);
      end
    end
    return w;
  endfunction

  // gnt_q is one-hot on the owner, so it doubles as the owner mask.
  assign owner_req  = |(bus.req & gnt_q);
  assign others     = bus.req & ~gnt_q;
  assign owner_nxt  = (int'(gnt_idx_q) == N - 1) ? '0 : gnt_idx_q + IDXW'(1);
  assign scan_start = bus.rrMode ? ptr_q : '0;
  assign win_req    = pick(bus.req, scan_start);
  // Preemption always scans from just past the owner so the owner goes last.
  assign win_pre    = pick(others, owner_nxt);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.en && |bus.req) begin
          gnt_d      = N'(1) << win_req;
          gnt_idx_d  = win_req;
          hold_cnt_d = HCW'(1);
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (bus.rrMode) ptr_d = owner_nxt;
          if (bus.en && |bus.req) begin
            gnt_d      = N'(1) << win_req;
            gnt_idx_d  = win_req;
            hold_cnt_d = HCW'(1);
          end else begin
            gnt_d      = '0;
            hold_cnt_d = '0;
            state_d    = IDLE;
          end
        end else if (MAX_HOLD > 0 && hold_cnt_q == HOLD_SAT && bus.en && |others) begin
          if (bus.rrMode) ptr_d = owner_nxt;
          gnt_d      = N'(1) << win_pre;
          gnt_idx_d  = win_pre;
          hold_cnt_d = HCW'(1);
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gntValid = gnt_valid_q;
  assign bus.gntIdx   = gnt_idx_q;
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter: three arbiters (N=4/MAX_HOLD=3, N=4/MAX_HOLD=0,
// N=5/MAX_HOLD=3) share one stimulus stream; each is compared every cycle
// against a behavioural model, plus directed scenario checks.
module tb_rr_hold_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rr;
  logic [4:0] req_s;

  int n_checks = 0;
  int n_fail   = 0;

  rr_hold_arbiter_if #(.N(4)) if_a ();
  rr_hold_arbiter_if #(.N(4)) if_b ();
  rr_hold_arbiter_if #(.N(5)) if_c ();

  assign if_a.en = en;  assign if_a.rrMode = rr;  assign if_a.req = req_s[3:0];
  assign if_b.en = en;  assign if_b.rrMode = rr;  assign if_b.req = req_s[3:0];
  assign if_c.en = en;  assign if_c.rrMode = rr;  assign if_c.req = req_s;

  rr_hold_arbiter #(.N(4), .MAX_HOLD(3)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  rr_hold_arbiter #(.N(4), .MAX_HOLD(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  rr_hold_arbiter #(.N(5), .MAX_HOLD(3)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  always #5 clk = ~clk;

  // Reference model state, one entry per instance (owner = -1 when idle).
  int m_n[3]  = '{4, 4, 5};
  int m_mh[3] = '{3, 0, 3};
  int m_owner[3];
  int m_last[3];
  int m_ptr[3];
  int m_hold[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input int n, input int mask, input int start);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (start + k) % n;
      if (((mask >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic step(input int i);
    int n, r, others, start, nw;
    n = m_n[i];
    r = int'(req_s) & ((1 << n) - 1);
    if (rst) begin
      m_owner[i] = -1; m_last[i] = 0; m_ptr[i] = 0; m_hold[i] = 0;
    end else if (m_owner[i] < 0) begin
      if (en && r != 0) begin
        m_owner[i] = pick(n, r, rr ? m_ptr[i] : 0);
        m_hold[i]  = 1;
      end
    end else if (((r >> m_owner[i]) & 1) == 0) begin
      start = rr ? m_ptr[i] : 0;
      if (rr) m_ptr[i] = (m_owner[i] + 1) % n;
      if (en && r != 0) begin
        m_owner[i] = pick(n, r, start);
        m_hold[i]  = 1;
      end else begin
        m_owner[i] = -1;
        m_hold[i]  = 0;
      end
    end else begin
      others = r & ~(1 << m_owner[i]);
      if (m_mh[i] > 0 && m_hold[i] == m_mh[i] && en && others != 0) begin
        nw = pick(n, others, (m_owner[i] + 1) % n);
        if (rr) m_ptr[i] = (m_owner[i] + 1) % n;
        m_owner[i] = nw;
        m_hold[i]  = 1;
      end else if (m_mh[i] == 0 || m_hold[i] < m_mh[i]) begin
        m_hold[i]++;
      end
    end
    if (m_owner[i] >= 0) m_last[i] = m_owner[i];
  endtask

  task automatic check_inst(input string nm, input int i, input logic [4:0] g,
                            input logic v, input logic [2:0] idx);
    int eg;
    eg = (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0;
    chk({nm, "_gnt"},    32'(g),   32'(eg));
    chk({nm, "_valid"},  32'(v),   32'(m_owner[i] >= 0));
    chk({nm, "_idx"},    32'(idx), 32'(m_last[i]));
    chk({nm, "_onehot"}, 32'($onehot0(g)), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 3; i++) step(i);
    #1;
    check_inst("a", 0, {1'b0, if_a.gnt}, if_a.gntValid, {1'b0, if_a.gntIdx});
    check_inst("b", 1, {1'b0, if_b.gnt}, if_b.gntValid, {1'b0, if_b.gntIdx});
    check_inst("c", 2, if_c.gnt, if_c.gntValid, if_c.gntIdx);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_s = '0;
    cycle();
    rst = 1'b0;
  endtask

  int exp_rr[5]   = '{0, 1, 2, 3, 0};
  int exp_pre[9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
  int exp_fix[7]  = '{0, 0, 0, 1, 1, 1, 0};

  initial begin
    rst = 1'b1; en = 1'b1; rr = 1'b0; req_s = '0;
    cycle();
    cycle();
    chk("rst_gnt", 32'(if_a.gnt), 32'd0);
    chk("rst_idx", 32'(if_a.gntIdx), 32'd0);

    // Fixed priority first grant, then reset mid-grant.
    rst = 1'b0; req_s = 5'b01010;
    cycle();
    chk("fix_gnt", 32'(if_a.gnt), 32'b0010);
    chk("fix_idx", 32'(if_a.gntIdx), 32'd1);
    rst = 1'b1;
    cycle();
    chk("midrst_gnt", 32'(if_a.gnt), 32'd0);
    chk("midrst_idx", 32'(if_a.gntIdx), 32'd0);

    // Round-robin fairness: owner drops its request once granted.
    do_reset();
    rr = 1'b1; req_s = 5'b01111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_idx", 32'(if_a.gntIdx), 32'(exp_rr[k]));
      chk("rr_valid", 32'(if_a.gntValid), 32'd1);
      req_s = 5'b01111 & ~{1'b0, if_a.gnt};
    end

    // Preemption in round-robin, then a lone owner keeps its grant.
    do_reset();
    rr = 1'b1; req_s = 5'b00011;
    for (int k = 0; k < 9; k++) begin
      cycle();
      chk("pre_idx", 32'(if_a.gntIdx), 32'(exp_pre[k]));
    end
    req_s = 5'b00001;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("alone_gnt", 32'(if_a.gnt), 32'b0001);
    end

    // Fixed priority: unlimited hold starves 1, limit of 3 rotates.
    do_reset();
    rr = 1'b0; req_s = 5'b00011;
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk("lim_idx", 32'(if_a.gntIdx), 32'(exp_fix[k]));
      chk("nolim_idx", 32'(if_b.gntIdx), 32'd0);
    end

    // en gating.
    do_reset();
    rr = 1'b0; en = 1'b1; req_s = 5'b00100;
    cycle();
    chk("en_idx", 32'(if_a.gntIdx), 32'd2);
    en = 1'b0; req_s = 5'b01100;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("en_hold_gnt", 32'(if_a.gnt), 32'b0100);
    end
    req_s = 5'b01000;
    cycle();
    chk("en_rel_gnt", 32'(if_a.gnt), 32'd0);
    chk("en_rel_idx", 32'(if_a.gntIdx), 32'd2);
    en = 1'b1;
    cycle();
    chk("en_re_gnt", 32'(if_a.gnt), 32'b1000);

    // N=5 wrap: owner 4 releases, next grant is 1.
    do_reset();
    rr = 1'b1; req_s = 5'b10000;
    cycle();
    chk("wrap_own", 32'(if_c.gntIdx), 32'd4);
    req_s = 5'b00110;
    cycle();
    chk("wrap_idx", 32'(if_c.gntIdx), 32'd1);
    chk("wrap_valid", 32'(if_c.gntValid), 32'd1);

    // Random sticky requests with occasional mode flips, en drops and resets.
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 3) == 0) req_s[b] = ~req_s[b];
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) rr = ~rr;
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Registered N-way arbiter with a selectable policy: fixed priority (lowest index wins) or round-robin.
- A grant is held until the owner drops its request. An optional hold limit forces the owner to give way when other requesters are waiting.
- Sits in front of shared resources such as the divider datapath, where several issuers compete for one unit and a grant must stay stable for a multi-cycle operation.

Parameters:
- N, 8, number of requesters (N >= 1).
- MAX_HOLD, 16, maximum consecutive grant cycles before preemption when others wait; 0 = unlimited.
- IDXW, max(1,$clog2(N)), derived width of the grant index; not to be overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  allows new grants; does not revoke an existing grant.
- rrMode  input  1  1 = round-robin, 0 = fixed priority (lowest index).
- req  input  N  request vector, one bit per requester.
- gnt  output  N  registered one-hot grant (all zero when none).
- gntValid  output  1  registered, equals |gnt.
- gntIdx  output  IDXW  registered index of owner; holds last owner when gntValid=0.

Behaviour:
- Single clock (clk), synchronous active-high reset (rst); all state updates on the rising edge of clk.
- Reset: gnt=0, gntValid=0, gntIdx=0, round-robin pointer ptr=0, hold counter holdCnt=0, state IDLE. Reset mid-grant drops the grant on that edge.
- Winner selection (combinational, from a masked request vector M):
  - Fixed priority: lowest set index of M.
  - Round-robin: first set index of M scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (wraps; N need not be a power of 2).
- Latency: req sampled at edge k produces gnt at edge k (visible in cycle k+1). One cycle from request to grant; no combinational path from req to gnt.
- State IDLE:
  - en=1 and |req → gnt=onehot(winner, M=req), gntIdx=winner, gntValid=1, holdCnt=1, go GRANT.
  - Otherwise remain IDLE with outputs zero.
- State GRANT (owner = gntIdx). Events are evaluated in this priority order:
  1. Release, req[owner]=0. If en=1 and any other req is set, hand over to winner(M=req) on the same edge with no idle cycle; holdCnt=1. Otherwise gnt=0, gntValid=0, go IDLE.
  2. Preemption: MAX_HOLD>0, holdCnt==MAX_HOLD, en=1, and (req with the owner bit cleared) is nonzero. Grant winner(M=req with owner bit cleared), with the scan start forced to owner+1 in both modes; holdCnt=1.
  3. Otherwise the owner keeps the grant; holdCnt increments, saturating at MAX_HOLD (or at counter max when MAX_HOLD=0).
- Pointer update: on every grant change (release or preemption), in round-robin mode, ptr = (owner+1) mod N. In fixed mode ptr is unchanged.
- en=0 during GRANT: the owner keeps the grant until release, and preemption is suppressed. On release go IDLE.
- rrMode may change at any time; it affects only the next winner selection and never revokes a current grant.
- Owner alone requesting at MAX_HOLD: the grant is kept and holdCnt stays saturated. Preemption fires as soon as another request appears.
- N=1: gntIdx is always 0; gnt follows req with one-cycle latency; preemption never fires.
- Invariant: gnt is one-hot or zero at all times. gnt[i]=1 implies req[i] was 1 at the granting edge.

Test Plan (N=4, MAX_HOLD=3 unless stated):
- Reset then req=4'b1010, rrMode=0 → next cycle gnt=4'b0010, gntIdx=1. Assert rst mid-grant → gnt=0, gntIdx=0 one cycle later.
- Round-robin fairness: rrMode=1, each requester drops its req one cycle after being granted, req=4'b1111 otherwise held → grants cycle 0,1,2,3,0, one change per release, no idle cycles between.
- Preemption: rrMode=1, req=4'b0011 held constantly → gntIdx=0 for 3 cycles, then 1 for 3 cycles, then 0. With req=4'b0001 only, grant to 0 persists indefinitely.
- Fixed starvation vs limit: rrMode=0, MAX_HOLD=0, req=4'b0011 constant → gntIdx=0 forever. Same with MAX_HOLD=3 → 0 (3 cycles), then 1 (3 cycles), then back to 0.
- en gating: grant held by 2, en dropped, req=4'b1100 → grant 2 retained past MAX_HOLD. req[2] drops → gnt=0, IDLE. en=1 → gnt=4'b1000 one cycle later.
- Wrap with N=5, rrMode=1: owner 4 releases while req=5'b00110 → ptr=0, next grant index 1. Check one-hot invariant every cycle under random req.
